// File: rtl/security_response_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : security_pkg
//  Description : Shared level encoding and timing constants for the security
//                response path (also used by the upstream hazard controller).
//  Revision    : 1.0 - initial release
// ============================================================================
package security_pkg;

    // Security level as produced by the hazard controller
    typedef logic [1:0] security_level_t;

    localparam security_level_t LVL_NONE  = 2'd0;
    localparam security_level_t LVL_WARN  = 2'd1;
    localparam security_level_t LVL_ALERT = 2'd2;
    localparam security_level_t LVL_LOCK  = 2'd3;

    // Base tick rate: every timer in the block is measured in these ticks
    localparam int TICKS_PER_SEC = 8;

endpackage : security_pkg
`default_nettype wire

// File: rtl/security_response_controller_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divider producing a one-cycle base_tick pulse
//                every DIV clocks. Only rst clears the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic base_tick
);

    if (DIV > 1) begin : g_count
        localparam int              c_cnt_w = $clog2(DIV);
        localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

        logic [c_cnt_w-1:0] r_cnt;

        // Count 0..DIV-1 and reload to zero after the terminal count
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign base_tick = (r_cnt == c_last);
    end else begin : g_every_cycle
        // Degenerate divider: every clock is a tick
        assign base_tick = 1'b1;
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/security_response_controller.sv
`default_nettype none
// ============================================================================
//  Module      : security_response_controller
//  Description : Latches the hazard controller's security level and drives
//                the alarm LED, buzzer and door lock. Levels escalate at
//                once, drop only on acknowledge, and LOCKDOWN needs a
//                sustained acknowledge to release.
//  Options     : `define SECURITY_AUTO_DECAY_EN to let WARN/ALERT decay one
//                step after HOLD_IN_SEC seconds without a fresh escalation.
//  Revision    : 1.0 - initial release
// ============================================================================
module security_response_controller
    import security_pkg::*;
#(
    parameter int CLOCK_RATE      = 100_000_000,
    parameter int HOLD_IN_SEC     = 5,
    parameter int ACK_HOLD_IN_SEC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  security_level_t security_level,
    input  logic            ack,
    output security_level_t active_level,
    output logic            alarm_led,
    output logic            buzzer,
    output logic            door_lock
);

    localparam int                 c_tick_div  = CLOCK_RATE / TICKS_PER_SEC;
    localparam int                 c_ack_ticks = ACK_HOLD_IN_SEC * TICKS_PER_SEC;
    localparam int                 c_ack_w     = $clog2(c_ack_ticks + 1);
    localparam logic [c_ack_w-1:0] c_ack_max   = c_ack_w'(c_ack_ticks);
    // WARN blinks with a phase change every four base ticks
    localparam logic [1:0]         c_warn_last = 2'd3;

    if ((CLOCK_RATE % TICKS_PER_SEC) != 0 || CLOCK_RATE < TICKS_PER_SEC ||
        HOLD_IN_SEC < 1 || ACK_HOLD_IN_SEC < 1) begin : g_cfg_invalid
        $error("security_response_controller: unsupported timing parameters");
    end

    logic               w_base_tick;
    logic               w_escalate;
    logic               w_decay_req;
    security_level_t    r_level;
    security_level_t    w_level_nxt;
    logic [c_ack_w-1:0] r_ack_cnt;
    logic [c_ack_w-1:0] w_ack_cnt_nxt;
    logic [1:0]         r_blink_cnt;
    logic [1:0]         w_blink_cnt_nxt;
    logic               r_phase;
    logic               w_phase_nxt;
    logic               r_alarm_led;
    logic               r_buzzer;
    logic               r_door_lock;
    logic               w_led_nxt;
    logic               w_buzzer_nxt;
    logic               w_lock_nxt;

    tick_prescaler #(
        .DIV (c_tick_div)
    ) u_tick_prescaler (
        .clk       (clk),
        .rst       (rst),
        .base_tick (w_base_tick)
    );

    assign w_escalate = (security_level > r_level);

`ifdef SECURITY_AUTO_DECAY_EN
    localparam int                  c_hold_ticks = HOLD_IN_SEC * TICKS_PER_SEC;
    localparam int                  c_hold_w     = $clog2(c_hold_ticks + 1);
    localparam logic [c_hold_w-1:0] c_hold_max   = c_hold_w'(c_hold_ticks);

    logic [c_hold_w-1:0] r_hold;
    logic                w_decay_go;

    // Decay is only offered to WARN/ALERT sitting above the input once the hold expires
    assign w_decay_req = (r_hold == '0) && (r_level == LVL_WARN || r_level == LVL_ALERT)
                         && (r_level > security_level);
    // An acknowledge in the same cycle outranks decay
    assign w_decay_go  = w_decay_req && !ack;

    // Hold timer: reload on escalation or a decay step, otherwise count down on ticks to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_escalate || w_decay_go) begin
            r_hold <= c_hold_max;
        end else if (w_base_tick && (r_hold != '0)) begin
            r_hold <= r_hold - 1'b1;
        end
    end
`else
    assign w_decay_req = 1'b0;
`endif

    // Level FSM: escalate > lockdown release > ack clear > decay
    always_comb begin
        w_level_nxt   = r_level;
        w_ack_cnt_nxt = '0;
        if (w_escalate) begin
            w_level_nxt = security_level;
        end else if (r_level == LVL_LOCK) begin
            if (r_ack_cnt == c_ack_max) begin
                // Acknowledge held long enough: fall to whatever the input says now
                w_level_nxt = security_level;
            end else if (ack) begin
                w_ack_cnt_nxt = w_base_tick ? (r_ack_cnt + 1'b1) : r_ack_cnt;
            end
        end else if (ack) begin
            // No escalation here, so the input is never above the current level
            w_level_nxt = security_level;
        end else if (w_decay_req) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Blink generator: restart lit on any level change, then advance on base ticks
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt;
        w_phase_nxt     = r_phase;
        if (w_level_nxt != r_level) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = 1'b1;
        end else if (w_base_tick) begin
            if (r_level == LVL_WARN) begin
                if (r_blink_cnt == c_warn_last) begin
                    w_blink_cnt_nxt = '0;
                    w_phase_nxt     = ~r_phase;
                end else begin
                    w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                end
            end else if (r_level == LVL_ALERT) begin
                w_blink_cnt_nxt = '0;
                w_phase_nxt     = ~r_phase;
            end
        end
    end

    // Output decode from the next state so the registered outputs track active_level
    always_comb begin
        w_led_nxt    = 1'b0;
        w_buzzer_nxt = 1'b0;
        w_lock_nxt   = 1'b0;
        case (w_level_nxt)
            LVL_WARN: begin
                w_led_nxt = w_phase_nxt;
            end
            LVL_ALERT: begin
                w_led_nxt    = w_phase_nxt;
                w_buzzer_nxt = w_phase_nxt;
            end
            LVL_LOCK: begin
                w_led_nxt    = 1'b1;
                w_buzzer_nxt = 1'b1;
                w_lock_nxt   = 1'b1;
            end
            default: begin
                w_led_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level     <= LVL_NONE;
            r_ack_cnt   <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_alarm_led <= 1'b0;
            r_buzzer    <= 1'b0;
            r_door_lock <= 1'b0;
        end else begin
            r_level     <= w_level_nxt;
            r_ack_cnt   <= w_ack_cnt_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_alarm_led <= w_led_nxt;
            r_buzzer    <= w_buzzer_nxt;
            r_door_lock <= w_lock_nxt;
        end
    end

    assign active_level = r_level;
    assign alarm_led    = r_alarm_led;
    assign buzzer       = r_buzzer;
    assign door_lock    = r_door_lock;

endmodule : security_response_controller
`default_nettype wire

// File: doc/security_response_controller.md
# security_response_controller

Consumes the 2-bit `security_level` produced by the hazard controller and turns it into physical responses: a latched alarm level, a blinking alarm LED, a buzzer and a door-lock output. Levels escalate immediately, are held until an operator acknowledge, and a full lockdown needs a sustained acknowledge to release. The block sits directly downstream of the hazard controller and drives the board I/O.

## Interface
- `CLOCK_RATE`, 100_000_000: clk frequency in Hz; must be a multiple of 8.
- `HOLD_IN_SEC`, 5: hold time before auto-decay, in seconds. Used only with the macro in Configuration.
- `ACK_HOLD_IN_SEC`, 2: how long `ack` must be held continuously to release lockdown, in seconds.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `security_level` in 2: level from the hazard controller (0..3). Registered upstream and stable between updates.
- `ack` in 1: operator acknowledge, level-sensitive and already synchronised.
- `active_level` out 2: latched response level.
- `alarm_led` out 1: alarm indicator.
- `buzzer` out 1: buzzer enable.
- `door_lock` out 1: lock actuator; 1 means locked.

## Operation
- Base tick:
  - A free-running prescaler counts 0..TICK_DIV-1, where TICK_DIV = CLOCK_RATE/8.
  - `base_tick` is a 1-cycle pulse when the count equals TICK_DIV-1, giving 8 ticks/s.
  - The prescaler is never cleared except by `rst`.
- States follow `active_level`: NONE(0), WARN(1), ALERT(2), LOCKDOWN(3).
- Priority per cycle, highest first: escalate, then lockdown release, then ack clear, then decay.
  - **Escalate:** if `security_level > active_level`, load `security_level` and reload the hold timer. This applies from any state.
  - **Ack clear (WARN/ALERT):** while `ack`=1, `active_level` takes `security_level` (never below the input).
  - **Lockdown release:**
    - In LOCKDOWN, `ack_cnt` increments on each `base_tick` while `ack`=1 and clears to 0 in any cycle `ack`=0.
    - When `ack_cnt` reaches ACK_HOLD_IN_SEC*8, load `security_level` and clear `ack_cnt`. If the input is still 3, the block stays in LOCKDOWN.
  - A lower `security_level` without ack or decay is ignored (latching).
- Level change:
  - Any change of `active_level` clears the blink counter and sets the blink phase to on.
  - `ack_cnt` is cleared outside LOCKDOWN.
- Output decode, using the registered next state:
  - NONE: `alarm_led`=0, `buzzer`=0, `door_lock`=0.
  - WARN: `alarm_led` toggles every 4 base ticks (1 Hz); `buzzer`=0; `door_lock`=0.
  - ALERT: `alarm_led` toggles every base tick (4 Hz); `buzzer` equals `alarm_led`; `door_lock`=0.
  - LOCKDOWN: `alarm_led`=1, `buzzer`=1, `door_lock`=1.
- Widths:
  - Prescaler counter: $clog2(TICK_DIV) bits.
  - Hold timer: $clog2(HOLD_IN_SEC*8+1) bits.
  - `ack_cnt`: $clog2(ACK_HOLD_IN_SEC*8+1) bits.
  - All counters saturate or reload and never wrap.

## Timing
- Reset: every output is 0, and the prescaler, blink counter, hold timer and `ack_cnt` are cleared. A reset asserted mid-lockdown returns to NONE on the next edge.
- Latency: all outputs are registered. A `security_level` change at edge N appears on `active_level`, `alarm_led`, `buzzer` and `door_lock` after edge N (1 cycle).
- Ack clear: the 1-cycle latency from `ack` rising applies.
- Lockdown release: `active_level` changes on the edge after the `base_tick` on which `ack_cnt` hits its limit.
- Simultaneous events:
  - Escalation in the same cycle as `ack` wins, and `ack` is ignored that cycle.
  - `ack` deasserting on the same cycle as the final tick means no release.

## Configuration
- `SECURITY_AUTO_DECAY_EN` defined:
  - The hold timer counts down on each `base_tick` from HOLD_IN_SEC*8.
  - At 0, if `active_level` is WARN or ALERT and greater than `security_level`, `active_level` decrements by one and the timer reloads.
  - LOCKDOWN never decays.
- Not defined: the hold timer logic is compiled out, and levels drop only via ack or lockdown release.

## Structure
- Package `security_pkg`: level constants `LVL_NONE`, `LVL_WARN`, `LVL_ALERT`, `LVL_LOCK`; `TICKS_PER_SEC`=8; a `security_level_t` 2-bit typedef shared with the hazard controller.
- Sub-module `tick_prescaler` (parameter DIV, outputs `base_tick`).
- The level FSM, the blink generator and output decode stay in the top module.

## Test plan
All scenarios use CLOCK_RATE=80 (TICK_DIV=10), so one second is 80 cycles.
- Level 1 input after reset: `active_level`=1 one cycle later; `alarm_led`=1 for 40 cycles, then 0 for 40; `buzzer`=0.
- Input steps 1 then 3 with no ack: `active_level`=3 next cycle; `door_lock`=`buzzer`=`alarm_led`=1. The input then drops to 0 and `active_level` stays 3.
- LOCKDOWN, input 0, `ack` held 160 cycles: release to 0 at the 16th tick. Repeat with `ack` dropped at cycle 100 and then held 150 cycles: no release.
- ALERT, input 3 and `ack` in the same cycle: `active_level`=3 and `ack` is ignored.
- With `SECURITY_AUTO_DECAY_EN`, ALERT and input 0: after 400 cycles `active_level`=1, and after 800 it is 0. Without the macro it stays 2.
- `rst` pulsed mid-lockdown: all outputs 0 on the following edge.
